// File: rtl/nobl_pkg.sv
// nobl_pkg: shared defaults, index type and round-robin helper
// for the NoBL SRAM arbiter slice.
package nobl_pkg;

  localparam int NOBL_WIDTH    = 18;
  localparam int NOBL_DEPTH    = 19;
  localparam int NOBL_NREQ     = 4;
  localparam int NOBL_READ_LAT = 4;
  localparam int NOBL_IDX_W    = $clog2(NOBL_NREQ);

  typedef logic [NOBL_IDX_W-1:0] req_idx_t;

  function automatic int rr_idx(
    input int last,
    input int k,
    input int n
  );
    return (last + 1 + k) % n;
  endfunction

endpackage

// File: rtl/nobl_arb_if.sv
// nobl_arb_if: requester-side bus of the NoBL arbiter,
// packed per requester.
interface nobl_arb_if #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 19,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*DEPTH-1:0] addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic [NREQ-1:0]       rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/nobl_arb_tagq.sv
// nobl_arb_tagq: FIFO of requester indices for reads that
// are in flight to the SRAM.
module nobl_arb_tagq #(
  parameter int IW   = 2,
  parameter int LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [IW-1:0] i_idx,
  input  logic          i_pop,
  output logic [IW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [LOG2:0] o_count
);

  localparam int D = 1 << LOG2;

  logic [IW-1:0]   r_mem [D];
  logic [LOG2-1:0] r_wp;
  logic [LOG2-1:0] r_rp;
  logic [LOG2:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = r_cnt[LOG2];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < D; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_idx;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case (1'b1)
        (w_push & ~w_pop): r_cnt <= r_cnt + 1'b1;
        (w_pop & ~w_push): r_cnt <= r_cnt - 1'b1;
        default:           r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/nobl_arb.sv
// nobl_arb: round-robin sharing of one nobl_if among NREQ requesters.
// Define NOBL_ARB_PRIO_EN for bounded fixed priority of requester 0.
module nobl_arb
  import nobl_pkg::*;
#(
  parameter int WIDTH     = NOBL_WIDTH,
  parameter int DEPTH     = NOBL_DEPTH,
  parameter int NREQ      = NOBL_NREQ,
  parameter int TAGQ_LOG2 = 3,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  nobl_arb_if.slave        bus,
  output logic [DEPTH-1:0] address,
  output logic [WIDTH-1:0] data_out,
  output logic             write,
  output logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             busy,
  output logic             err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("nobl_arb: unsupported NREQ or MAX_BURST");
  end

  logic [NREQ-1:0]    w_cand;
  logic [NREQ-1:0]    w_cand_m;
  logic               w_pri0;
  logic               w_any;
  logic [IW-1:0]      w_gidx;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      r_last;
  logic               w_full;
  logic               w_empty;
  logic [IW-1:0]      w_head;
  logic [TAGQ_LOG2:0] w_cnt;
  logic               w_push;
  logic               w_pop;
  logic [DEPTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic               r_write;
  logic               r_en;
  logic               r_err;

  // Reads need a tag slot; writes never wait on the queue.
  assign w_cand = bus.req & (bus.we | {NREQ{~w_full}});

`ifdef NOBL_ARB_PRIO_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] r_burst;
  logic          w_mask0;

  assign w_mask0  = (r_burst == BW'(MAX_BURST))
                  && (|w_cand[NREQ-1:1]);
  assign w_cand_m = w_cand
                  & ~{{(NREQ-1){1'b0}}, w_mask0};
  assign w_pri0   = w_cand_m[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (w_any && w_gidx == '0) begin
      if (r_burst != BW'(MAX_BURST)) begin
        r_burst <= r_burst + 1'b1;
      end
    end else begin
      r_burst <= '0;
    end
  end
`else
  assign w_cand_m = w_cand;
  assign w_pri0   = 1'b0;
`endif

  always_comb begin
    w_any  = 1'b0;
    w_gidx = r_last;
    w_idx  = '0;
    if (w_pri0) begin
      w_any  = 1'b1;
      w_gidx = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        w_idx = IW'(rr_idx(int'(r_last), k, NREQ));
        if (!w_any && w_cand_m[w_idx]) begin
          w_any  = 1'b1;
          w_gidx = w_idx;
        end
      end
    end
    // No grant may leak out while reset is asserted.
    w_any = w_any & rst_n;
  end

  assign bus.gnt = w_any ? (NREQ'(1) << w_gidx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IW'(NREQ - 1);
    end else if (w_any) begin
      r_last <= w_gidx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_en    <= 1'b0;
    end else if (w_any) begin
      r_addr  <= bus.addr[w_gidx*DEPTH +: DEPTH];
      r_wdata <= bus.wdata[w_gidx*WIDTH +: WIDTH];
      r_write <= bus.we[w_gidx];
      r_en    <= 1'b1;
    end else begin
      r_write <= 1'b0;
      r_en    <= 1'b0;
    end
  end

  assign address  = r_addr;
  assign data_out = r_wdata;
  assign write    = r_write;
  assign enable   = r_en;

  assign w_push = w_any & ~bus.we[w_gidx];
  assign w_pop  = data_in_valid & ~w_empty;

  nobl_arb_tagq #(
    .IW   (IW),
    .LOG2 (TAGQ_LOG2)
  ) u_tagq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_idx   (w_gidx),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign bus.rdata  = data_in;
  assign bus.rvalid = w_pop ? (NREQ'(1) << w_head) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (data_in_valid && w_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err  = r_err;
  assign busy = (w_cnt != '0);

endmodule

// File: tb/tb_nobl_arb.sv
// tb_nobl_arb: directed checks of nobl_arb against a
// fixed-latency SRAM return model.
module tb_nobl_arb;
  import nobl_pkg::*;

  localparam int W  = 18;
  localparam int D  = 19;
  localparam int N  = 4;
  localparam int QL = 3;
  localparam int L  = NOBL_READ_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nobl_arb_if #(.WIDTH(W), .DEPTH(D), .NREQ(N)) bus ();

  logic [D-1:0] address;
  logic [W-1:0] data_out;
  logic [W-1:0] data_in;
  logic         write;
  logic         enable;
  logic         data_in_valid;
  logic         busy;
  logic         err;

  nobl_arb #(
    .WIDTH     (W),
    .DEPTH     (D),
    .NREQ      (N),
    .TAGQ_LOG2 (QL),
    .MAX_BURST (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .address       (address),
    .data_out      (data_out),
    .write         (write),
    .enable        (enable),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .busy          (busy),
    .err           (err)
  );

  logic [W-1:0] mem [256];
  logic         auto_ret;
  logic         man_v;
  logic [W-1:0] man_d;
  logic [L-1:0] pv;
  logic [W-1:0] pd [L];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[L-2:0], enable & ~write & auto_ret};
      pd[0] <= mem[address[7:0]];
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  end

  assign data_in_valid = auto_ret ? pv[L-1] : man_v;
  assign data_in       = auto_ret ? pd[L-1] : man_d;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [D-1:0] a, input logic [W-1:0] d);
    bus.req[i]          = r;
    bus.we[i]           = w;
    bus.addr[i*D +: D]  = a;
    bus.wdata[i*W +: W] = d;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},  32'(bus.gnt),    32'h0);
    check({tag, "_rv"},   32'(bus.rvalid), 32'h0);
    check({tag, "_en"},   32'(enable),     32'h0);
    check({tag, "_wr"},   32'(write),      32'h0);
    check({tag, "_addr"}, 32'(address),    32'h0);
    check({tag, "_dout"}, 32'(data_out),   32'h0);
    check({tag, "_err"},  32'(err),        32'h0);
    check({tag, "_busy"}, 32'(busy),       32'h0);
  endtask

`ifdef NOBL_ARB_PRIO_EN
  int rr_exp [8]   = '{0, 0, 0, 0, 1, 0, 0, 0};
  int pr_exp [10]  = '{1, 1, 1, 1, 8, 1, 1, 1, 1, 8};
`else
  int rr_exp [8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
  int pr_exp [10]  = '{1, 8, 1, 8, 1, 8, 1, 8, 1, 8};
`endif
  int tg_gnt [3]   = '{4, 1, 8};
  int tg_rv  [9]   = '{0, 0, 0, 0, 0, 4, 1, 8, 0};
  int tg_dat [9]   = '{0, 0, 0, 0, 0, 'h1A10, 'h2B20, 'h3C30, 0};

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    auto_ret  = 1'b1;
    man_v     = 1'b0;
    man_d     = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 18'h1A10;
    mem[8'h20] = 18'h2B20;
    mem[8'h30] = 18'h3C30;

    // reset state
    repeat (2) @(posedge clk);
    smp();
    check_zero("rst");
    cyc();
    rst_n = 1'b1;

    // round robin, all writes
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b1, D'('h100 + i), W'('h200 + i));
    for (int k = 0; k < 8; k++) begin
      smp();
      check("rr_gnt", 32'(bus.gnt), 32'(1) << rr_exp[k]);
      if (k > 0) begin
        check("rr_en", 32'(enable), 32'h1);
        check("rr_addr", 32'(address), 32'('h100 + rr_exp[k-1]));
      end
      cyc();
    end
    bus.req = '0;
    smp();
    check("rr_gnt_idle", 32'(bus.gnt), 32'h0);
    check("rr_en_last", 32'(enable), 32'h1);
    check("rr_dout", 32'(data_out), 32'('h200 + rr_exp[7]));
    check("rr_wr", 32'(write), 32'h1);
    cyc();
    smp();
    check("idle_en", 32'(enable), 32'h0);
    check("idle_wr", 32'(write), 32'h0);
    check("idle_addr", 32'(address), 32'('h100 + rr_exp[7]));
    cyc();

    // read tag routing
    for (int c = 0; c < 9; c++) begin
      bus.req = '0;
      if (c == 0) set_req(2, 1'b1, 1'b0, D'('h10), '0);
      if (c == 1) set_req(0, 1'b1, 1'b0, D'('h20), '0);
      if (c == 2) set_req(3, 1'b1, 1'b0, D'('h30), '0);
      smp();
      if (c < 3) check("tag_gnt", 32'(bus.gnt), 32'(tg_gnt[c]));
      if (c == 3) check("tag_busy", 32'(busy), 32'h1);
      check("tag_rv", 32'(bus.rvalid), 32'(tg_rv[c]));
      if (tg_rv[c] != 0)
        check("tag_rdata", 32'(bus.rdata), 32'(tg_dat[c]));
      cyc();
    end
    smp();
    check("tag_busy_end", 32'(busy), 32'h0);
    check("tag_err", 32'(err), 32'h0);
    cyc();

    // full queue with stalled returns
    auto_ret = 1'b0;
    set_req(1, 1'b1, 1'b0, D'('h40), '0);
    for (int k = 0; k < 8; k++) begin
      smp();
      check("full_gnt", 32'(bus.gnt), 32'h2);
      cyc();
    end
    set_req(2, 1'b1, 1'b1, D'('h50), W'('h3FFFF));
    smp();
    check("full_wr_gnt", 32'(bus.gnt), 32'h4);
    check("full_busy", 32'(busy), 32'h1);
    cyc();
    set_req(2, 1'b0, 1'b1, D'('h50), W'('h3FFFF));
    smp();
    check("full_block", 32'(bus.gnt), 32'h0);
    cyc();
    man_v = 1'b1;
    man_d = W'('h155);
    smp();
    check("full_pop_gnt", 32'(bus.gnt), 32'h0);
    check("full_pop_rv", 32'(bus.rvalid), 32'h2);
    check("full_pop_rd", 32'(bus.rdata), 32'h155);
    cyc();
    man_v = 1'b0;
    smp();
    check("full_reopen", 32'(bus.gnt), 32'h2);
    cyc();
    bus.req = '0;
    for (int k = 0; k < 8; k++) begin
      man_v = 1'b1;
      man_d = W'(k + 1);
      smp();
      check("drain_rv", 32'(bus.rvalid), 32'h2);
      check("drain_rd", 32'(bus.rdata), 32'(k + 1));
      cyc();
    end
    man_v = 1'b0;
    smp();
    check("drain_busy", 32'(busy), 32'h0);
    check("drain_err", 32'(err), 32'h0);
    cyc();

    // spurious return
    man_v = 1'b1;
    smp();
    check("spur_rv", 32'(bus.rvalid), 32'h0);
    cyc();
    man_v = 1'b0;
    smp();
    check("spur_err", 32'(err), 32'h1);
    cyc();
    smp();
    check("spur_sticky", 32'(err), 32'h1);
    cyc();

    // reset in the middle of read traffic
    auto_ret = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b0, D'('h10), '0);
    cyc();
    smp();
    check("mid_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    bus.we = '1;
    #1;
    check_zero("mid_rst");
    cyc();
    rst_n = 1'b1;
    smp();
    check("rst_first", 32'(bus.gnt), 32'h1);
    cyc();
    bus.req = '0;
    repeat (8) cyc();
    smp();
    check("rst_no_err", 32'(err), 32'h0);
    cyc();

    // requester 0 against requester 3, fresh arbiter state
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, D'('h60), W'('h1));
    set_req(3, 1'b1, 1'b1, D'('h63), W'('h2));
    for (int k = 0; k < 10; k++) begin
      smp();
      check("prio_gnt", 32'(bus.gnt), 32'(pr_exp[k]));
      cyc();
    end
    bus.req = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nobl_arb.md
# nobl_arb

Round-robin arbiter that shares one NoBL/ZBT SRAM interface (`nobl_if`) among `NREQ` independent single-word requesters. It accepts one read or write per cycle from a requester, drives the SRAM command port one cycle later and tags each read so its return data reaches the requester that issued it. It sits between DSP/packet-buffer clients and `nobl_if`, in place of a single dedicated FIFO owner.

## Interface
- `WIDTH`, 18, SRAM data width
- `DEPTH`, 19, SRAM address width
- `NREQ`, 4, number of requesters (2..8)
- `TAGQ_LOG2`, 3, log2 of the read-tag queue depth (8 outstanding reads)
- `MAX_BURST`, 4, consecutive requester-0 grants allowed in priority mode

- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — asynchronous assert, active-low reset
- `req` in NREQ — request per requester; held with `we`/`addr`/`wdata` until `gnt`
- `we` in NREQ — 1 = write, 0 = read
- `addr` in NREQ*DEPTH — packed addresses, requester i at `[i*DEPTH +: DEPTH]`
- `wdata` in NREQ*WIDTH — packed write data
- `gnt` out NREQ — one-hot, combinational; request accepted this cycle
- `rdata` out WIDTH — read data, broadcast to all requesters
- `rvalid` out NREQ — one-hot, qualifies `rdata` for requester i
- `address` out DEPTH, `data_out` out WIDTH, `write` out 1, `enable` out 1 — registered command to `nobl_if`
- `data_in` in WIDTH, `data_in_valid` in 1 — read return from `nobl_if`
- `busy` out 1 — tag queue non-empty
- `err` out 1 — sticky; return with no outstanding tag

## Operation
- Each cycle at most one grant. Candidates: requesters with `req` high, excluding reads when the tag queue is full (writes still granted).
- Round-robin: search starts at `last+1` mod NREQ. `last` updates to the granted index on every grant and holds when there is no grant.
- Granted command is registered: `address`, `data_out`, `write`=`we[i]`, `enable`=1 on the next cycle. With no grant, `enable`=0, `write`=0, and `address`/`data_out` hold.
- A read grant pushes index i into the tag queue in the grant cycle. `data_in_valid` pops the head: `rvalid[head]`=1 and `rdata`=`data_in`, both combinational from `data_in`.
- Push and pop in the same cycle leave the count unchanged. Full means count == 2^TAGQ_LOG2, and a pop that cycle does not free the slot for that cycle's grant.
- `data_in_valid` with the queue empty sets `err`; `rvalid` stays 0. `err` clears only on reset.
- `busy` = count != 0.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `enable`=0, `write`=0, `address`=0, `data_out`=0, `err`=0, `busy`=0. Also `last`=NREQ-1, so requester 0 is searched first. Tag queue is emptied.
- Reset mid-operation: queued tags are discarded. A `data_in_valid` that arrives after reset sets `err`; `nobl_if` shares `rst_n`, so this cannot occur in-system.
- Grant at cycle t puts the command on the `nobl_if` port at t+1. `rvalid` coincides with `data_in_valid`, which is t+1 plus the `nobl_if` read latency (4), i.e. t+5.
- Back-to-back grants to different or the same requester are allowed every cycle, with no read/write turnaround bubble.
- Requester handshake: the requester may drop `req` in the cycle after `gnt` or re-present a new request. `req` with no `gnt` must hold its fields stable.

## Configuration
- `NOBL_ARB_PRIO_EN` defined: requester 0 has fixed priority over the round-robin search.
  - A burst counter (width clog2(MAX_BURST+1)) counts consecutive requester-0 grants.
  - At `MAX_BURST`, requester 0 is masked for exactly one arbitration cycle that has another requester eligible. The counter clears on any non-0 grant or idle cycle.
  - `last` still updates for non-0 grants.
- `NOBL_ARB_PRIO_EN` undefined: pure round-robin; no counter is built.

## Structure
- Shared package `nobl_pkg`: default `WIDTH`/`DEPTH`, `NOBL_READ_LAT`=4, and the requester-index type (width clog2(NREQ)).
- Sub-module `nobl_arb_tagq`: synchronous FIFO of requester indices, depth 2^TAGQ_LOG2, with push/pop/full/empty/count.
- The arbiter core (mask, rotate, priority-encode), command register and optional burst counter live in `nobl_arb`.

## Test plan
- **Reset:** drive `rst_n`=0 mid-traffic → all outputs 0 asynchronously. First grant after release goes to requester 0 when all `req`=1.
- **Round-robin:** all four hold `req` → `gnt` sequence 1,2,4,8,1,… with no gaps. `enable` stays 1 from t+1 onward.
- **Read tag routing:** requesters 2, 0, 3 read addresses 0x10, 0x20, 0x30 back-to-back → `rvalid` 4, 1, 8 in that order with the matching SRAM contents, each 5 cycles after its grant.
- **Full queue:** 9 back-to-back reads from requester 1 with returns stalled → 8 grants then `gnt`=0. A concurrent write from requester 2 is still granted. The first return re-enables read grants from the next cycle.
- **Spurious return:** `data_in_valid` pulse with the queue empty → `err`=1 and sticky, `rvalid`=0.
- **Priority (`NOBL_ARB_PRIO_EN`, `MAX_BURST`=4):** requesters 0 and 3 continuously request → grant pattern 0,0,0,0,3,0,0,0,0,3. Without the macro → 0,3,0,3.
